// File: rtl/duc_rate_sequencer.sv
// Strobe and rate sequencer for the TX DUC chain: CIC divider followed by
// NUM_HB optional x2 halfband stages, with shadowed rate settings.
module duc_rate_sequencer #(
  parameter logic [7:0] BASE      = 8'd0,
  parameter int         CIC_WIDTH = 8,
  parameter int         NUM_HB    = 2,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  input  logic                 run,
  input  logic                 sample_valid,
  output logic                 strobe_cic,
  output logic [NUM_HB-1:0]    strobe_hb,
  output logic                 strobe_in,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] underrun_count,
  output logic [CIC_WIDTH-1:0] active_rate,
  output logic [NUM_HB-1:0]    active_hb_en,
  output logic                 cfg_pending
);

  localparam logic [CIC_WIDTH-1:0] L_ONE = CIC_WIDTH'(1);

  logic [CIC_WIDTH-1:0] r_act_rate;
  logic [CIC_WIDTH-1:0] r_pend_rate;
  logic [CIC_WIDTH-1:0] r_cic_cnt;
  logic [NUM_HB-1:0]    r_act_hb;
  logic [NUM_HB-1:0]    r_pend_hb;
  logic [NUM_HB-1:0]    r_hb_ph;
  logic                 r_pend;
  logic                 r_strobe_cic;
  logic [NUM_HB-1:0]    r_strobe_hb;
  logic                 r_underrun;
  logic [CNT_WIDTH-1:0] r_ucnt;

  logic                 w_wr;
  logic [CIC_WIDTH-1:0] w_wr_rate;
  logic                 w_run;
  logic                 w_t_cic;
  logic [NUM_HB-1:0]    w_gate;
  logic [NUM_HB-1:0]    w_t_hb;
  logic [NUM_HB-1:0]    w_t_pre;
  logic                 w_t_in;
  logic                 w_starve;
  logic                 w_commit;

  assign w_wr      = set_stb && (set_addr == BASE);
  assign w_wr_rate = (set_data[CIC_WIDTH-1:0] == '0) ? L_ONE
                                                     : set_data[CIC_WIDTH-1:0];
  assign w_run     = run && !clr;
  assign w_t_cic   = w_run && (r_cic_cnt == '0);

  // A stage passes a terminal when bypassed or on its second input terminal
  assign w_gate = ~r_act_hb | r_hb_ph;

  for (genvar k = 0; k < NUM_HB; k++) begin : g_hb
    assign w_t_hb[k] = w_t_cic & (&w_gate[k:0]);
    if (k == 0) begin : g_first
      assign w_t_pre[k] = w_t_cic;
    end else begin : g_next
      assign w_t_pre[k] = w_t_hb[k-1];
    end
  end

  assign w_t_in   = w_t_hb[NUM_HB-1];
  assign w_starve = w_t_in && !sample_valid;
  // A coinciding write keeps the newer value pending
  assign w_commit = r_pend && !w_wr && (w_t_in || !run);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_rate <= L_ONE;
      r_pend_hb   <= '1;
      r_pend      <= 1'b0;
      r_act_rate  <= L_ONE;
      r_act_hb    <= '1;
    end else begin
      if (w_wr) begin
        r_pend_rate <= w_wr_rate;
        r_pend_hb   <= set_data[CIC_WIDTH +: NUM_HB];
        r_pend      <= 1'b1;
      end else if (w_commit) begin
        r_pend      <= 1'b0;
      end
      if (w_commit) begin
        r_act_rate <= r_pend_rate;
        r_act_hb   <= r_pend_hb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cic_cnt <= '0;
      r_hb_ph   <= '0;
    end else if (w_commit) begin
      r_cic_cnt <= r_pend_rate - L_ONE;
      r_hb_ph   <= '0;
    end else if (!w_run) begin
      r_cic_cnt <= r_act_rate - L_ONE;
      r_hb_ph   <= '0;
    end else begin
      r_cic_cnt <= w_t_cic ? (r_act_rate - L_ONE) : (r_cic_cnt - L_ONE);
      r_hb_ph   <= r_hb_ph ^ (w_t_pre & r_act_hb);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe_cic <= 1'b0;
      r_strobe_hb  <= '0;
      r_underrun   <= 1'b0;
      r_ucnt       <= '0;
    end else begin
      r_strobe_cic <= w_t_cic;
      r_strobe_hb  <= w_t_hb;
      r_underrun   <= w_starve;
      if (clr) begin
        r_ucnt <= '0;
      end else if (w_starve && (r_ucnt != '1)) begin
        r_ucnt <= r_ucnt + CNT_WIDTH'(1);
      end
    end
  end

  assign strobe_cic     = r_strobe_cic;
  assign strobe_hb      = r_strobe_hb;
  assign strobe_in      = r_strobe_hb[NUM_HB-1];
  assign underrun       = r_underrun;
  assign underrun_count = r_ucnt;
  assign active_rate    = r_act_rate;
  assign active_hb_en   = r_act_hb;
  assign cfg_pending    = r_pend;

endmodule

// File: tb/tb_duc_rate_sequencer.sv
// Directed bench for duc_rate_sequencer: table of rate configurations
// plus hand sequences for deferred commit, underrun, saturation and reset.
module tb_duc_rate_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic        run = 1'b0;
  logic        sv = 1'b1;
  logic        s_cic, s_in, s_ur, s_pend;
  logic [1:0]  s_hb, s_act_hb;
  logic [15:0] s_cnt;
  logic [7:0]  s_rate;

  logic        set_stb2 = 1'b0;
  logic        run2 = 1'b0;
  logic        sv2 = 1'b1;
  logic        t_cic, t_in, t_ur, t_pend;
  logic [1:0]  t_hb, t_act_hb, t_cnt;
  logic [7:0]  t_rate;

  always #5 clk = ~clk;

  duc_rate_sequencer #(.BASE(8'd0), .CIC_WIDTH(8), .NUM_HB(2),
                       .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .set_stb(set_stb),
    .set_addr(set_addr), .set_data(set_data), .run(run),
    .sample_valid(sv), .strobe_cic(s_cic), .strobe_hb(s_hb),
    .strobe_in(s_in), .underrun(s_ur), .underrun_count(s_cnt),
    .active_rate(s_rate), .active_hb_en(s_act_hb), .cfg_pending(s_pend)
  );

  duc_rate_sequencer #(.BASE(8'd0), .CIC_WIDTH(8), .NUM_HB(2),
                       .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .clr(1'b0), .set_stb(set_stb2),
    .set_addr(8'd0), .set_data(32'd0), .run(run2),
    .sample_valid(sv2), .strobe_cic(t_cic), .strobe_hb(t_hb),
    .strobe_in(t_in), .underrun(t_ur), .underrun_count(t_cnt),
    .active_rate(t_rate), .active_hb_en(t_act_hb), .cfg_pending(t_pend)
  );

  typedef struct {
    logic [7:0] rate;
    logic [1:0] hb;
    int         eff;
    int         p_hb0;
    int         p_in;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c1, c2, h1, h2, i1, i2, ncic, bad, tprev, pulses, got;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = 8'd0;
    set_data = d;
    step();
    set_stb  = 1'b0;
  endtask

  task automatic wait_in(output int ok);
    ok = 0;
    for (int n = 0; n < 64 && ok == 0; n++) begin
      step();
      if (s_in) ok = 1;
    end
  endtask

  initial begin
    vecs[0] = '{8'd4, 2'b11, 4, 8, 16};
    vecs[1] = '{8'd3, 2'b01, 3, 6, 6};
    vecs[2] = '{8'd0, 2'b00, 1, 1, 1};
    vecs[3] = '{8'd2, 2'b10, 2, 2, 4};
    vecs[4] = '{8'd5, 2'b00, 5, 5, 5};
    vecs[5] = '{8'd1, 2'b11, 1, 2, 4};

    step();
    chk("rst_strobe_cic", 32'(s_cic), 0);
    chk("rst_strobe_hb", 32'(s_hb), 0);
    chk("rst_count", 32'(s_cnt), 0);
    chk("rst_pending", 32'(s_pend), 0);
    chk("rst_rate", 32'(s_rate), 1);
    chk("rst_hb_en", 32'(s_act_hb), 3);
    step();
    rst = 1'b0;
    step();

    // Saturation on the narrow-counter instance
    set_stb2 = 1'b1;
    step();
    set_stb2 = 1'b0;
    step();
    run2 = 1'b1;
    sv2  = 1'b0;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (t_ur) pulses++;
    end
    run2 = 1'b0;
    sv2  = 1'b1;
    step();
    chk("sat_pulses", 32'(pulses), 5);
    chk("sat_count", 32'(t_cnt), 3);

    // Table of rate configurations
    for (int v = 0; v < 6; v++) begin
      run = 1'b0;
      wr({22'd0, vecs[v].hb, vecs[v].rate});
      chk("tbl_pending_set", 32'(s_pend), 1);
      step();
      chk("tbl_pending_clr", 32'(s_pend), 0);
      chk("tbl_active_rate", 32'(s_rate), 32'(vecs[v].eff));
      chk("tbl_active_hb", 32'(s_act_hb), 32'(vecs[v].hb));
      run = 1'b1;
      c1 = -1; c2 = -1; h1 = -1; h2 = -1; i1 = -1; i2 = -1;
      ncic = 0; bad = 0;
      for (int n = 1; n <= 48; n++) begin
        step();
        if (s_cic) begin
          ncic++;
          if (c1 < 0) c1 = n; else if (c2 < 0) c2 = n;
        end
        if (s_hb[0]) begin
          if (h1 < 0) h1 = n; else if (h2 < 0) h2 = n;
        end
        if (s_in) begin
          if (i1 < 0) i1 = n; else if (i2 < 0) i2 = n;
          if (!s_cic) bad++;
        end
      end
      chk("tbl_first_cic", 32'(c1), 32'(vecs[v].eff));
      chk("tbl_cic_period", 32'(c2 - c1), 32'(vecs[v].eff));
      chk("tbl_cic_count", 32'(ncic), 32'(48 / vecs[v].eff));
      chk("tbl_hb0_period", 32'(h2 - h1), 32'(vecs[v].p_hb0));
      chk("tbl_first_in", 32'(i1), 32'(vecs[v].p_in));
      chk("tbl_in_period", 32'(i2 - i1), 32'(vecs[v].p_in));
      chk("tbl_in_coincident", 32'(bad), 0);
      chk("tbl_underruns", 32'(s_cnt), 0);
      run = 1'b0;
      step();
    end

    // Deferred commit: rate 4/hb 11 running, rewrite to rate 2 mid-period
    wr(32'h304);
    step();
    run = 1'b1;
    wait_in(got);
    chk("dc_first_in", 32'(got), 1);
    tprev = cyc;
    for (int n = 0; n < 5; n++) step();
    wr(32'h302);
    chk("dc_pending", 32'(s_pend), 1);
    chk("dc_old_rate", 32'(s_rate), 4);
    wait_in(got);
    chk("dc_old_period", 32'(cyc - tprev), 16);
    chk("dc_new_rate", 32'(s_rate), 2);
    chk("dc_pending_clr", 32'(s_pend), 0);
    tprev = cyc;
    wait_in(got);
    chk("dc_new_period", 32'(cyc - tprev), 8);

    // Underrun counting at period 16
    run = 1'b0;
    wr(32'h304);
    step();
    run = 1'b1;
    wait_in(got);
    sv = 1'b0;
    pulses = 0; bad = 0; i1 = 0;
    for (int n = 0; n < 80 && i1 < 3; n++) begin
      step();
      if (s_ur) pulses++;
      if (s_ur != s_in) bad++;
      if (s_in) i1++;
    end
    sv = 1'b1;
    chk("ur_pulses", 32'(pulses), 3);
    chk("ur_align", 32'(bad), 0);
    chk("ur_count", 32'(s_cnt), 3);
    wait_in(got);
    chk("ur_count_hold", 32'(s_cnt), 3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ur_clr", 32'(s_cnt), 0);

    // Asynchronous reset while strobing with a nonzero count
    sv = 1'b0;
    wait_in(got);
    sv = 1'b1;
    chk("ar_count_pre", 32'(s_cnt), 1);
    got = 0;
    for (int n = 0; n < 8 && got == 0; n++) begin
      step();
      if (s_cic) got = 1;
    end
    chk("ar_cic_seen", 32'(got), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_strobe_cic", 32'(s_cic), 0);
    chk("ar_strobe_hb", 32'(s_hb), 0);
    chk("ar_count", 32'(s_cnt), 0);
    chk("ar_rate", 32'(s_rate), 1);
    chk("ar_hb_en", 32'(s_act_hb), 3);
    step();
    chk("ar_held", 32'(s_cic), 0);
    rst = 1'b0;
    ncic = 0; i1 = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (s_cic) ncic++;
      if (s_in) i1++;
    end
    chk("ar_cic_every", 32'(ncic), 8);
    chk("ar_in_count", 32'(i1), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/duc_rate_sequencer.md
Name: duc_rate_sequencer

Overview:
- Parametrised strobe and rate sequencer for the TX DUC chain.
- Generalises the fixed CIC plus two-halfband strober cascade to NUM_HB halfband stages, each with its own enable and a CIC rate of configurable width.
- New rate settings are shadowed and committed only on an input-sample boundary or while idle, so strobes never glitch mid-cycle.
- Tracks baseband underruns: a sample is requested while the upstream source has none valid.

Parameters:
- BASE, 0: settings-bus address of the rate register.
- CIC_WIDTH, 8: width of the CIC interpolation rate field.
- NUM_HB, 2: number of halfband x2 stages. Range 1..4.
- CNT_WIDTH, 16: width of the underrun counter.

Ports:
- clk  in  1  DSP clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous clear: counters and phase only, settings kept.
- set_stb  in  1  settings-bus strobe.
- set_addr  in  8  settings-bus address.
- set_data  in  32  settings-bus data.
- run  in  1  TX run enable from TX control.
- sample_valid  in  1  upstream sample available at strobe_in.
- strobe_cic  out  1  CIC input-rate strobe.
- strobe_hb  out  NUM_HB  per-stage input strobe. Index 0 is adjacent to the CIC.
- strobe_in  out  1  baseband sample request, equal to strobe_hb[NUM_HB-1].
- underrun  out  1  one-cycle pulse on a starved request.
- underrun_count  out  CNT_WIDTH  saturating count of starved requests.
- active_rate  out  CIC_WIDTH  committed CIC rate.
- active_hb_en  out  NUM_HB  committed halfband enables.
- cfg_pending  out  1  a written setting awaits commit.

Behaviour:
- Rate register at BASE:
  - set_data[CIC_WIDTH-1:0] is cic_rate. A value of 0 is treated as 1.
  - set_data[CIC_WIDTH+NUM_HB-1:CIC_WIDTH] is hb_en.
  - A write loads the pending registers and sets cfg_pending the next cycle.
- Commit:
  - Pending values move to the active registers on the cycle after an internal strobe_in terminal, or on any cycle with run=0.
  - cfg_pending clears in the same cycle as the commit.
  - A write that coincides with a commit overrides it: the new value stays pending and cfg_pending stays 1.
  - Commit also reloads all divider counters.
- Reset values:
  - All strobes, underrun, underrun_count and cfg_pending are 0.
  - active_rate and pending rate are 1.
  - active_hb_en and pending enables are all ones.
- Dividers:
  - CIC counter runs down from active_rate-1 to 0. Its terminal is at 0.
  - Stage k divides the previous terminal by 2 when hb_en[k]=1 and passes it through when hb_en[k]=0.
  - All terminals coincide on their common cycle.
  - Total period of strobe_in is active_rate * 2^(popcount hb_en).
- Output timing:
  - Strobes are registered, one cycle after the internal terminal.
  - With run=0, or in the cycle of clr, counters are held at their reload values and the strobes are 0.
  - The first strobe_cic appears active_rate cycles after run rises. This includes the case active_rate=1, which gives a strobe every cycle from the cycle after run rises.
- Underrun:
  - When strobe_in=1 and sample_valid=0, underrun pulses for 1 cycle, registered alongside strobe_in.
  - underrun_count increments and saturates at all ones.
  - clr zeroes the count. If clr and an underrun occur in the same cycle, clr wins.
- Reset mid-operation: outputs go to their reset values immediately, with no partial strobe. After release, behaviour is as from a cold start.
- A run drop mid-period aborts the period. A restart begins a full period; no partial period is replayed.

Test Plan:
- Basic periods:
  - Stimulus: reset, write rate=4 with hb_en=2'b11, run=1, sample_valid=1.
  - Required: strobe_cic every 4 cycles, strobe_hb[0] every 8, strobe_in every 16, all strobe_in coincident with strobe_cic, underrun_count=0.
- Halfband bypass:
  - Stimulus: rate=3, hb_en=2'b01.
  - Required: strobe_hb[0] and strobe_in both every 6 cycles.
- Zero rate and back-to-back strobes:
  - Stimulus: rate=0, hb_en=0.
  - Required: strobe_cic=strobe_in=1 every cycle from the cycle after run rises.
- Deferred commit:
  - Stimulus: running at rate 4, hb_en 11; write rate=2 mid-period.
  - Required: cfg_pending=1, old 16-cycle period completes, commit on the following cycle, subsequent strobe_in period 8, cfg_pending=0.
- Underrun counting:
  - Stimulus: period 16, sample_valid=0 for 3 strobe_in events, then clr.
  - Required: 3 underrun pulses, underrun_count=3, then 0 after clr. Separately, with CNT_WIDTH=2 and 5 starvations, the count saturates at 3.
- Asynchronous reset:
  - Stimulus: assert rst mid-period.
  - Required: all outputs 0 and active_rate=1 without waiting for a clock edge. After release with run=1, strobes every cycle until rate is reprogrammed.
